// File: rtl/dead_anim_ctrl_pkg.sv
// rtl/dead_anim_ctrl_pkg.sv - shared state type and default geometry/timing for the death animation
package dead_anim_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_SPR_W       = 64;
    localparam int DEF_SPR_H       = 64;
    localparam int DEF_NUM_FRAMES  = 4;
    localparam int DEF_FRAME_TICKS = 8;

endpackage

// File: rtl/anim_tick_div.sv
// rtl/anim_tick_div.sv - counts vsync ticks, pulses advance on every FRAME_TICKS-th one
module anim_tick_div
    import dead_anim_ctrl_pkg::*;
#(
    parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic advance
);

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    logic [CW-1:0] cnt;

    // clear wins over tick so a tick coinciding with a (re)start is never counted
    assign advance = tick && !clear && (cnt == CW'(FRAME_TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (advance) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dead_anim_ctrl.sv
// rtl/dead_anim_ctrl.sv - death animation sequencer with sprite ROM addressing and 3-cycle pixel pipeline
module dead_anim_ctrl
    import dead_anim_ctrl_pkg::*;
#(
    parameter int SPR_W           = DEF_SPR_W,
    parameter int SPR_H           = DEF_SPR_H,
    parameter int NUM_FRAMES      = DEF_NUM_FRAMES,
    parameter int FRAME_TICKS     = DEF_FRAME_TICKS,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        vsync_tick,
    input  logic        trigger,
    input  logic [9:0]  SpriteX,
    input  logic [9:0]  SpriteY,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [13:0] rom_addr,
    input  logic [3:0]  rom_q,
    output logic [3:0]  pal_index,
    output logic        sprite_on,
    output logic        busy,
    output logic        done,
    output logic [1:0]  frame_num
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);

    state_t      state, state_n;
    logic [1:0]  frame_n;
    logic        done_n;
    logic        tick_clear;
    logic        advance;

    anim_tick_div #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_tick_div (
        .clk     (Clk),
        .reset   (Reset),
        .clear   (tick_clear),
        .tick    (vsync_tick),
        .advance (advance)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            frame_num <= 2'd0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            frame_num <= frame_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        frame_n    = frame_num;
        done_n     = 1'b0;
        tick_clear = (state != PLAY);
        case (state)
            IDLE, HOLD: begin
                if (trigger) begin
                    state_n = PLAY;
                    frame_n = 2'd0;
                end
            end
            PLAY: begin
                if (advance) begin
                    frame_n = frame_num + 2'd1;
                    if (frame_n == 2'(NUM_FRAMES - 1)) begin
                        state_n = HOLD;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == PLAY);

    // 11-bit compares so a sprite near the right/bottom edge does not wrap
    logic          x_in, y_in, pix_valid;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [13:0]   addr_n;
    logic          valid_d1, valid_d2;
    logic          opaque;

    assign x_in = ({1'b0, DrawX} >= {1'b0, SpriteX}) &&
                  ({1'b0, DrawX} <  ({1'b0, SpriteX} + 11'(SPR_W)));
    assign y_in = ({1'b0, DrawY} >= {1'b0, SpriteY}) &&
                  ({1'b0, DrawY} <  ({1'b0, SpriteY} + 11'(SPR_H)));
    assign pix_valid = x_in && y_in && (state != IDLE);
    assign col    = CW'(DrawX - SpriteX);
    assign row    = RW'(DrawY - SpriteY);
    assign addr_n = (14'(frame_num) << (CW + RW)) | (14'(row) << CW) | 14'(col);
    assign opaque = valid_d2 && (rom_q != 4'(TRANSPARENT_IDX));

    // valid_d2 lines up with rom_q, which the external ROM returns one cycle after rom_addr
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr  <= 14'd0;
            valid_d1  <= 1'b0;
            valid_d2  <= 1'b0;
            sprite_on <= 1'b0;
            pal_index <= 4'd0;
        end else begin
            rom_addr  <= pix_valid ? addr_n : 14'd0;
            valid_d1  <= pix_valid;
            valid_d2  <= valid_d1;
            sprite_on <= opaque;
            pal_index <= opaque ? rom_q : 4'd0;
        end
    end

endmodule

// File: tb/tb_dead_anim_ctrl.sv
// tb/tb_dead_anim_ctrl.sv - directed vector bench for dead_anim_ctrl
module tb_dead_anim_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        vsync_tick = 1'b0;
    logic        trigger = 1'b0;
    logic [9:0]  SpriteX = 10'd0, SpriteY = 10'd0, DrawX = 10'd0, DrawY = 10'd0;
    logic [13:0] rom_addr;
    logic [3:0]  rom_q = 4'hA;
    logic [3:0]  pal_index;
    logic        sprite_on, busy, done;
    logic [1:0]  frame_num;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    dead_anim_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .vsync_tick (vsync_tick),
        .trigger    (trigger),
        .SpriteX    (SpriteX),
        .SpriteY    (SpriteY),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .rom_addr   (rom_addr),
        .rom_q      (rom_q),
        .pal_index  (pal_index),
        .sprite_on  (sprite_on),
        .busy       (busy),
        .done       (done),
        .frame_num  (frame_num)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (done) done_cnt++;

    typedef struct {
        logic [9:0]  sx, sy, dx, dy;
        logic [3:0]  rom;
        logic [13:0] addr;
        logic        on;
        logic [3:0]  pal;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk) vsync_tick = 1'b1;
            @(negedge Clk) vsync_tick = 1'b0;
        end
    endtask

    task automatic pulse_trigger();
        @(negedge Clk) trigger = 1'b1;
        @(negedge Clk) trigger = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        @(negedge Clk);
        SpriteX = v.sx; SpriteY = v.sy; DrawX = v.dx; DrawY = v.dy; rom_q = 4'hA;
        @(posedge Clk); #1;
        chk({tag, " rom_addr"}, rom_addr, v.addr);
        @(negedge Clk);
        DrawX = v.sx - 10'd1;
        @(posedge Clk); #1;
        chk({tag, " early sprite_on"}, sprite_on, 0);
        @(negedge Clk);
        rom_q = v.rom;
        @(posedge Clk); #1;
        chk({tag, " sprite_on"}, sprite_on, v.on);
        chk({tag, " pal_index"}, pal_index, v.pal);
        @(negedge Clk);
        rom_q = 4'hA;
    endtask

    initial begin
        vecs[0] = '{10'd100, 10'd50,   10'd105,  10'd52,   4'd7,  14'd8325,  1'b1, 4'd7};
        vecs[1] = '{10'd100, 10'd50,   10'd105,  10'd52,   4'd0,  14'd8325,  1'b0, 4'd0};
        vecs[2] = '{10'd100, 10'd50,   10'd164,  10'd52,   4'd7,  14'd0,     1'b0, 4'd0};
        vecs[3] = '{10'd600, 10'd10,   10'd639,  10'd10,   4'd5,  14'd8231,  1'b1, 4'd5};
        vecs[4] = '{10'd600, 10'd10,   10'd599,  10'd10,   4'd5,  14'd0,     1'b0, 4'd0};
        vecs[5] = '{10'd100, 10'd50,   10'd163,  10'd113,  4'd15, 14'd12287, 1'b1, 4'd15};
        vecs[6] = '{10'd100, 10'd50,   10'd100,  10'd114,  4'd3,  14'd0,     1'b0, 4'd0};
        vecs[7] = '{10'd960, 10'd1000, 10'd1023, 10'd1023, 4'd9,  14'd9727,  1'b1, 4'd9};
        vecs[8] = '{10'd100, 10'd50,   10'd99,   10'd50,   4'd4,  14'd0,     1'b0, 4'd0};

        repeat (3) @(posedge Clk);
        @(negedge Clk) Reset = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset frame_num", frame_num, 0);
        chk("reset rom_addr", rom_addr, 0);
        chk("reset sprite_on", sprite_on, 0);
        chk("reset pal_index", pal_index, 0);
        chk("reset done", done, 0);

        apply_vec('{10'd100, 10'd50, 10'd105, 10'd52, 4'd7, 14'd0, 1'b0, 4'd0}, "idle");

        // start with a coincident tick that must not be counted
        @(negedge Clk) begin trigger = 1'b1; vsync_tick = 1'b1; end
        @(negedge Clk) begin trigger = 1'b0; vsync_tick = 1'b0; end
        chk("start busy", busy, 1);
        chk("start frame", frame_num, 0);
        tick_n(7);
        chk("frame after 7", frame_num, 0);
        tick_n(1);
        chk("frame after 8", frame_num, 1);
        tick_n(4);
        pulse_trigger();
        tick_n(4);
        chk("frame after 16 w/ trigger", frame_num, 2);
        chk("busy frame2", busy, 1);

        for (int i = 0; i < 9; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        tick_n(7);
        chk("frame before last", frame_num, 2);
        chk("no early done", done_cnt, 0);
        @(negedge Clk) vsync_tick = 1'b1;
        @(posedge Clk); #1;
        chk("last frame", frame_num, 3);
        chk("done pulse", done, 1);
        chk("busy in hold", busy, 0);
        @(negedge Clk) vsync_tick = 1'b0;
        @(posedge Clk); #1;
        chk("done one cycle", done, 0);
        tick_n(10);
        chk("hold frame", frame_num, 3);
        chk("done count", done_cnt, 1);
        apply_vec('{10'd100, 10'd50, 10'd101, 10'd51, 4'd6, 14'd12353, 1'b1, 4'd6}, "hold");

        pulse_trigger();
        chk("restart frame", frame_num, 0);
        chk("restart busy", busy, 1);

        tick_n(23);
        chk("pre-reset frame", frame_num, 2);
        @(negedge Clk) begin SpriteX = 10'd100; SpriteY = 10'd50; DrawX = 10'd105; DrawY = 10'd52; rom_q = 4'd7; end
        repeat (3) @(posedge Clk);
        #1 chk("pre-reset sprite_on", sprite_on, 1);
        @(negedge Clk) begin Reset = 1'b1; vsync_tick = 1'b1; trigger = 1'b1; end
        @(posedge Clk); #1;
        chk("mid reset busy", busy, 0);
        chk("mid reset frame", frame_num, 0);
        chk("mid reset done", done, 0);
        chk("mid reset rom_addr", rom_addr, 0);
        chk("mid reset sprite_on", sprite_on, 0);
        chk("mid reset pal_index", pal_index, 0);
        @(negedge Clk) begin Reset = 1'b0; vsync_tick = 1'b0; trigger = 1'b0; end
        repeat (3) @(posedge Clk);
        #1 chk("idle after reset sprite_on", sprite_on, 0);
        chk("done count after reset", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dead_anim_ctrl.md
DEAD_ANIM_CTRL -- requirements
Module: dead_anim_ctrl

Interface
REQ-001 Parameter SPR_W, default 64: sprite width in pixels; a power of two.
REQ-002 Parameter SPR_H, default 64: sprite height in pixels; a power of two.
REQ-003 Parameter NUM_FRAMES, default 4: number of animation frames stored in ROM.
REQ-004 Parameter FRAME_TICKS, default 8: vsync ticks per animation frame; minimum 1.
REQ-005 Parameter TRANSPARENT_IDX, default 0: palette index treated as transparent (magenta key).
REQ-006 Clk  input  1  system clock; the block uses one clock only.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 vsync_tick  input  1  one-cycle pulse, once per video frame.
REQ-009 trigger  input  1  one-cycle request to start the death animation.
REQ-010 SpriteX, SpriteY  input  10 each  top-left sprite position in screen pixels.
REQ-011 DrawX, DrawY  input  10 each  current pixel coordinate, sampled every cycle.
REQ-012 rom_addr  output  14  sprite ROM address: frame*SPR_W*SPR_H + row*SPR_W + col.
REQ-013 rom_q  input  4  ROM palette index, valid exactly 1 cycle after rom_addr.
REQ-014 pal_index  output  4  palette index for the downstream palette lookup.
REQ-015 sprite_on  output  1  high when pal_index is an opaque sprite pixel.
REQ-016 busy  output  1  high in state PLAY.
REQ-017 done  output  1  one-cycle pulse when the last frame is reached.
REQ-018 frame_num  output  2  current animation frame.

Function
REQ-019 FSM states SHALL be IDLE, PLAY and HOLD; reset state is IDLE.
REQ-020 IDLE: a trigger SHALL move the FSM to PLAY with frame_num=0 and tick count=0; a vsync_tick in the same cycle SHALL NOT be counted.
REQ-021 PLAY: each vsync_tick SHALL increment the tick count; at count FRAME_TICKS-1 the count SHALL clear and frame_num SHALL increment.
REQ-022 PLAY: when frame_num advances into NUM_FRAMES-1, the FSM SHALL enter HOLD and done SHALL pulse for that one cycle.
REQ-023 PLAY: trigger SHALL be ignored.
REQ-024 HOLD: frame_num SHALL stay at NUM_FRAMES-1; a trigger SHALL restart per REQ-020, and vsync_tick SHALL be ignored.
REQ-025 In-box test: DrawX>=SpriteX and DrawX<SpriteX+SPR_W, evaluated at 11 bits so the sum does not wrap; the same rule applies to Y with SPR_H.
REQ-026 rom_addr SHALL be registered: valid 1 cycle after DrawX/DrawY are sampled; it SHALL be 0 when out of box or in IDLE.
REQ-027 pal_index and sprite_on SHALL be registered from rom_q and a delayed in-box/active flag; total latency from DrawX/DrawY to these outputs is 3 cycles.
REQ-028 sprite_on SHALL be 1 only if in box, state is not IDLE and rom_q!=TRANSPARENT_IDX.
REQ-029 pal_index SHALL be 0 whenever sprite_on=0.
REQ-030 frame_num used for rom_addr SHALL be the value in the sampling cycle; a frame change mid-scan takes effect from the next sampled pixel.

Reset
REQ-031 Reset SHALL take effect on the Clk edge in which it is high, including mid-animation.
REQ-032 After reset: state=IDLE, tick count=0, frame_num=0, rom_addr=0, pal_index=0, sprite_on=0, busy=0, done=0, all pipeline flags cleared.
REQ-033 Reset SHALL take priority over trigger and vsync_tick in the same cycle.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE/PLAY/HOLD) and default SPR_W, SPR_H, NUM_FRAMES, FRAME_TICKS constants.
REQ-035 One sub-module, anim_tick_div, SHALL implement the FRAME_TICKS tick counter, with inputs clear/tick and a one-cycle advance pulse.
REQ-036 The ROM and the palette lookup SHALL remain outside the block.

Verification
REQ-037 Reset, then trigger, then 8 vsync_ticks -> frame_num=1 after the 8th tick; after 24 ticks, frame_num=3, done pulses once, busy=0, state=HOLD.
REQ-038 SpriteX=100, SpriteY=50, frame_num=2, DrawX=105, DrawY=52 -> rom_addr=2*4096+2*64+5=8325 one cycle later; rom_q=7 -> pal_index=7, sprite_on=1, 3 cycles after the sample.
REQ-039 Same position with rom_q=0 -> sprite_on=0, pal_index=0; DrawX=164 (out of box) -> rom_addr=0, sprite_on=0.
REQ-040 SpriteX=600, DrawX=639 -> in box (col 39); DrawX=599 -> out of box; no wrap.
REQ-041 trigger and vsync_tick in the same cycle from IDLE -> PLAY with tick count 0; trigger during PLAY -> frame sequence unchanged; trigger in HOLD -> frame_num=0, busy=1.
REQ-042 Reset asserted in PLAY at frame 2 -> next cycle IDLE, all outputs at reset values, no done pulse.
